// File: rtl/fat32_volume_parser.sv
// fat32_volume_parser: mounts a FAT32 volume from sector 0 (MBR or superfloppy) and derives its region addresses
module fat32_volume_parser #(
  parameter int PartitionIndex = 0,
  parameter int SectorSize = 512,
  parameter int indexWidth = 9
) (
  input  logic                  Clock,
  input  logic                  sys_rst,
  input  logic                  Start,
  output logic [31:0]           RequestSector,
  output logic                  RequestValid,
  input  logic                  ByteValid,
  input  logic [indexWidth-1:0] ByteAddress,
  input  logic [7:0]            ByteData,
  output logic                  Busy,
  output logic                  ParamValid,
  output logic                  Error,
  output logic [2:0]            ErrorCode,
  output logic [31:0]           PartitionStart,
  output logic [31:0]           FATStartSector,
  output logic [31:0]           DataStartSector,
  output logic [31:0]           RootDirSector,
  output logic [31:0]           FATLength,
  output logic [31:0]           RootClusterNumber,
  output logic [15:0]           ReservedSectors,
  output logic [7:0]            SectorsPerCluster,
  output logic [7:0]            NumberOfFAT
);
  typedef enum logic [3:0] {IDLE, REQ0, RECV0, CHECK0, REQ1, RECV1, CHECK1, COMPUTE, FINAL, DONE, ERROR} state_t;
  localparam int entry_base = 'h1BE + 16 * PartitionIndex;
  localparam logic [indexWidth-1:0] last_addr = indexWidth'(SectorSize - 1);
  state_t state, state_n;
  logic [7:0] jump, ptype;
  logic [15:0] bps, sig;
  logic [31:0] plba, product, fat_start, data_start;
  logic [2:0] cnt, sh, code_n;
  logic recv, last_byte, start_ok, sig_ok, dbr_ok, mbr_ok, root_lo;
  // Root-cluster range is only judged once a usable boot sector has been found
  always_comb begin
    recv = state == RECV0 || state == RECV1;
    last_byte = recv && ByteValid && ByteAddress == last_addr;
    start_ok = Start && (state == IDLE || state == DONE || state == ERROR);
    sig_ok = sig == 16'hAA55;
    dbr_ok = (jump == 8'hEB || jump == 8'hE9) && bps == 16'(SectorSize) && SectorsPerCluster != 8'd0 &&
             (SectorsPerCluster & (SectorsPerCluster - 8'd1)) == 8'd0 && NumberOfFAT != 8'd0;
    mbr_ok = (ptype == 8'h0B || ptype == 8'h0C) && plba != 32'd0;
    root_lo = RootClusterNumber < 32'd2;
    fat_start = PartitionStart + 32'(ReservedSectors);
    data_start = fat_start + product;
    sh = '0;
    for (int i = 0; i < 8; i++) if (SectorsPerCluster[i]) sh = 3'(i);
    code_n = state == CHECK0 ? (!sig_ok ? 3'd1 : dbr_ok ? (root_lo ? 3'd4 : 3'd0) : mbr_ok ? 3'd0 : 3'd2) :
             state == CHECK1 ? (!sig_ok ? 3'd1 : !dbr_ok ? 3'd3 : root_lo ? 3'd4 : 3'd0) : 3'd0;
    state_n = state;
    case (state)
      IDLE, DONE, ERROR: state_n = start_ok ? REQ0 : state;
      REQ0:    state_n = RECV0;
      RECV0:   state_n = last_byte ? CHECK0 : RECV0;
      CHECK0:  state_n = code_n != 3'd0 ? ERROR : dbr_ok ? COMPUTE : REQ1;
      REQ1:    state_n = RECV1;
      RECV1:   state_n = last_byte ? CHECK1 : RECV1;
      CHECK1:  state_n = code_n != 3'd0 ? ERROR : COMPUTE;
      COMPUTE: state_n = cnt == 3'd7 ? FINAL : COMPUTE;
      FINAL:   state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock) begin
    if (sys_rst) begin
      state <= IDLE;
      {RequestSector, RequestValid, Busy, ParamValid, Error, ErrorCode} <= '0;
      {PartitionStart, FATStartSector, DataStartSector, RootDirSector, FATLength, RootClusterNumber} <= '0;
      {ReservedSectors, SectorsPerCluster, NumberOfFAT} <= '0;
      {jump, ptype, bps, sig, plba, product, cnt} <= '0;
    end else begin
      state <= state_n;
      RequestValid <= state == REQ0 || state == REQ1;
      if (state == REQ0 || state == REQ1) RequestSector <= state == REQ0 ? 32'd0 : PartitionStart;
      if (recv && ByteValid) begin
        if (ByteAddress == indexWidth'(0)) jump <= ByteData;
        if (ByteAddress == indexWidth'(13)) SectorsPerCluster <= ByteData;
        if (ByteAddress == indexWidth'(16)) NumberOfFAT <= ByteData;
        if (ByteAddress == indexWidth'(entry_base + 4)) ptype <= ByteData;
        for (int i = 0; i < 2; i++) begin
          if (ByteAddress == indexWidth'(11 + i)) bps[8*i +: 8] <= ByteData;
          if (ByteAddress == indexWidth'(14 + i)) ReservedSectors[8*i +: 8] <= ByteData;
          if (ByteAddress == indexWidth'(510 + i)) sig[8*i +: 8] <= ByteData;
        end
        for (int i = 0; i < 4; i++) begin
          if (ByteAddress == indexWidth'(36 + i)) FATLength[8*i +: 8] <= ByteData;
          if (ByteAddress == indexWidth'(44 + i)) RootClusterNumber[8*i +: 8] <= ByteData;
          if (ByteAddress == indexWidth'(entry_base + 8 + i)) plba[8*i +: 8] <= ByteData;
        end
      end
      if (state == CHECK0) PartitionStart <= dbr_ok ? 32'd0 : plba;
      if (state == CHECK0 || state == CHECK1) begin
        product <= '0;
        cnt <= '0;
      end
      if (code_n != 3'd0) begin
        Error <= 1'b1;
        ErrorCode <= code_n;
        Busy <= 1'b0;
      end
      // Shift-add multiply: FATLength * NumberOfFAT, one multiplier bit per cycle
      if (state == COMPUTE) begin
        product <= NumberOfFAT[cnt] ? product + (FATLength << cnt) : product;
        cnt <= cnt + 3'd1;
      end
      if (state == FINAL) begin
        FATStartSector <= fat_start;
        DataStartSector <= data_start;
        RootDirSector <= data_start + ((RootClusterNumber - 32'd2) << sh);
      end
      if (state == DONE) begin
        ParamValid <= 1'b1;
        Busy <= 1'b0;
      end
      if (start_ok) begin
        ParamValid <= 1'b0;
        Error <= 1'b0;
        ErrorCode <= 3'd0;
        Busy <= 1'b1;
      end
    end
  end
endmodule
